// File: rtl/ecp5pll_phaser.sv
// ecp5pll_phaser: drives the ECP5 PLL dynamic phase-shift pins.
// It takes an absolute fine-phase target for one channel, works out the
// shortest wrap-around path from that channel's tracked offset, and then
// issues one SETUP/PULSE/GAP step sequence per fine step until the target
// is reached.
//
// Ports:
//   clk_i, reset        clock (PLL reference domain), synchronous active-high reset
//   locked              PLL lock; new steps only start while it is high
//   req_valid/req_ready request handshake carrying req_ch / req_phase
//   busy, done, err     status; done/err are one-cycle pulses
//   cur_phase           tracked offset per channel, channel k at [k*STEP_W +: STEP_W]
//   phasesel, phasedir, phasestep, phaseloadreg   PLL dynamic phase pins
module ecp5pll_phaser #(
  parameter int CHANNELS     = 4,
  parameter int STEP_W       = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset,
  input  logic                       locked,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_ch,
  input  logic [STEP_W-1:0]          req_phase,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [CHANNELS*STEP_W-1:0] cur_phase,
  output logic [1:0]                 phasesel,
  output logic                       phasedir,
  output logic                       phasestep,
  output logic                       phaseloadreg
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_SETUP, S_PULSE, S_GAP, S_DONE} state_t;

  state_t                           state;
  logic [CNT_W-1:0]                 cnt;
  logic [1:0]                       ch;
  logic [STEP_W-1:0]                tgt;
  logic [CHANNELS-1:0][STEP_W-1:0]  cur;

  logic [STEP_W-1:0] cur_sel;
  logic [STEP_W-1:0] diff;
  logic              ch_ok;

  // Offset of the latched channel and the modular distance to the target.
  always_comb begin
    cur_sel = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (32'(ch) == k) cur_sel = cur[k];
    diff  = tgt - cur_sel;
    ch_ok = (32'(ch) < CHANNELS);
  end

  assign cur_phase    = cur;
  assign phaseloadreg = 1'b0;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ch        <= '0;
      tgt       <= '0;
      cur       <= '0;
      phasesel  <= '0;
      phasedir  <= 1'b0;
      phasestep <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          ch        <= req_ch;
          tgt       <= req_phase;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= S_CALC;
        end
        S_CALC: begin
          if (!ch_ok) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_DONE;
          end else if (diff == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (locked) begin
            // MSB set means the downward path is no longer; the half-way tie decrements.
            phasesel <= ch;
            phasedir <= diff[STEP_W-1];
            cnt      <= CNT_W'(SETUP_CYCLES - 1);
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            phasestep <= 1'b1;
            cnt       <= CNT_W'(PULSE_CYCLES - 1);
            state     <= S_PULSE;
          end else cnt <= cnt - 1'b1;
        end
        S_PULSE: begin
          if (cnt == '0) begin
            // The PLL acts on the falling edge of phasestep; track it here.
            phasestep <= 1'b0;
            cnt       <= CNT_W'(GAP_CYCLES - 1);
            state     <= S_GAP;
            for (int k = 0; k < CHANNELS; k++)
              if (32'(ch) == k)
                cur[k] <= phasedir ? cur[k] - 1'b1 : cur[k] + 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        S_GAP: begin
          if (cnt == '0) state <= S_CALC;
          else           cnt   <= cnt - 1'b1;
        end
        S_DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecp5pll_phaser.sv
module tb_ecp5pll_phaser;
  localparam int CH = 3;
  localparam int SW = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             locked = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_ch = '0;
  logic [SW-1:0]    req_phase = '0;
  logic             busy, done, err;
  logic [CH*SW-1:0] cur_phase;
  logic [1:0]       phasesel;
  logic             phasedir, phasestep, phaseloadreg;

  int n_vec = 0;
  int n_bad = 0;

  ecp5pll_phaser #(.CHANNELS(CH), .STEP_W(SW)) dut (
    .clk_i(clk), .reset(reset), .locked(locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_phase(req_phase),
    .busy(busy), .done(done), .err(err), .cur_phase(cur_phase),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to done. Edge numbering: accepting edge = 0.
  // Each pulse is checked for width, sel/dir, and the offset update on its first low cycle.
  // drop_k > 0: drop locked right after the first pulse is seen, raise it drop_k edges later.
  task automatic run_req(input int ch, input int tgt, input int exp_dir, input int drop_k,
                         output int done_e, output int errv, output int np);
    int hi;
    int rel;
    logic prev;
    logic [7:0] expc;
    expc = (ch < CH) ? cur_phase[ch*SW +: SW] : 8'd0;
    req_ch = 2'(ch); req_phase = 8'(tgt); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    np = 0; hi = 0; prev = 1'b0; done_e = -1; errv = 0; rel = -1;
    for (int e = 1; e <= 3000; e++) begin
      tick();
      if (phasestep && !prev) begin
        np++;
        chk("pulse_sel", phasesel, ch);
        chk("pulse_dir", phasedir, exp_dir);
        if (np == 1 && drop_k > 0) begin
          locked = 1'b0;
          rel = e + drop_k;
        end
      end
      if (phasestep) hi++;
      if (!phasestep && prev) begin
        chk("pulse_width", hi, 4);
        expc = (exp_dir != 0) ? expc - 8'd1 : expc + 8'd1;
        chk("cur_update", cur_phase[ch*SW +: SW], expc);
        hi = 0;
      end
      if (e == rel) locked = 1'b1;
      prev = phasestep;
      if (done) begin
        done_e = e;
        errv = err;
        break;
      end
    end
    chk("done_seen", done, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("ready_back", req_ready, 1);
  endtask

  int de, ev, np;

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_step", phasestep, 0);
    chk("rst_cur", cur_phase, 0);
    chk("rst_done", done, 0);
    chk("loadreg", phaseloadreg, 0);

    // ch1: 0 -> 3, three increments
    run_req(1, 3, 0, 0, de, ev, np);
    chk("inc_pulses", np, 3);
    chk("inc_done_edge", de, 34);
    chk("inc_err", ev, 0);
    chk("inc_cur", cur_phase[1*SW +: SW], 3);

    // ch1: 3 -> 254, five decrements through 0
    run_req(1, 254, 1, 0, de, ev, np);
    chk("dec_pulses", np, 5);
    chk("dec_done_edge", de, 56);
    chk("dec_cur", cur_phase[1*SW +: SW], 254);

    // ch2 already at target
    run_req(2, 0, 0, 0, de, ev, np);
    chk("same_pulses", np, 0);
    chk("same_done_edge", de, 1);
    chk("same_err", ev, 0);

    // ch3 does not exist with three channels
    run_req(3, 7, 0, 0, de, ev, np);
    chk("badch_pulses", np, 0);
    chk("badch_done_edge", de, 1);
    chk("badch_err", ev, 1);
    chk("badch_cur", cur_phase, 24'h00FE00);

    // tie: ch0 0 -> 128 goes down 128 steps
    run_req(0, 128, 1, 0, de, ev, np);
    chk("tie_pulses", np, 128);
    chk("tie_done_edge", de, 1 + 128 * 11);
    chk("tie_cur", cur_phase[0 +: SW], 128);

    // lock loss: first pulse seen after edge 3, locked back after edge 21,
    // CALC stalls at edges 12..21 (10 cycles)
    run_req(0, 132, 0, 18, de, ev, np);
    chk("lock_pulses", np, 4);
    chk("lock_done_edge", de, 1 + 4 * 11 + 10);
    chk("lock_cur", cur_phase[0 +: SW], 132);

    // reset during a pulse
    req_ch = 2'd1; req_phase = 8'd10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !phasestep; i++) tick();
    chk("mid_step_seen", phasestep, 1);
    reset = 1'b1;
    tick();
    chk("midrst_step", phasestep, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_cur", cur_phase, 0);
    reset = 1'b0;

    run_req(1, 2, 0, 0, de, ev, np);
    chk("post_pulses", np, 2);
    chk("post_done_edge", de, 23);
    chk("post_cur", cur_phase, 24'h000200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
